// File: rtl/para_analysis_mc.sv
// Multi-channel parameter-packet analyser: validates 128-bit command packets, updates per-channel config.
// Optional checksum verification enabled with `define PARA_CHKSUM_EN.
module para_analysis_mc #(
    parameter int CH_NUM = 4,
    parameter int CH_W   = 2,
    parameter int THR_W  = 16,
    parameter int CYC_W  = 16
) (
    input  logic                    clk_25m,
    input  logic                    rst,
    input  logic                    pkt_valid,
    input  logic [127:0]            data_buffer,
    output logic                    pkt_ready,
    output logic                    para_cofi_flag,
    output logic [7:0]              para_ch,
    output logic [CH_NUM*THR_W-1:0] noise_threshold,
    output logic [CH_NUM*CYC_W-1:0] cycle_value,
    output logic [CH_NUM-1:0]       channel_en,
    output logic                    contin_mode_open,
    output logic                    pkt_err,
    output logic [1:0]              err_code,
    output logic [7:0]              err_cnt
);

    typedef enum logic [1:0] {IDLE, CHECK, APPLY} state_t;

    state_t state, state_nxt;

    logic [127:0]      pkt;
    logic [7:0]        hdr, cmd, ch;
    logic [CH_W-1:0]   ch_idx;
    logic              ch_ok, mode_ok, bcast;
    logic              chk_fail;
    logic [1:0]        chk_code;
    logic              pass_q;
    logic [1:0]        code_q;
    logic              unused_bits;

    logic [THR_W-1:0]  thr_r [CH_NUM];
    logic [CYC_W-1:0]  cyc_r [CH_NUM];

    always_ff @(posedge clk_25m) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pkt_valid) state_nxt = CHECK;
            CHECK:   state_nxt = APPLY;
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign pkt_ready = (state == IDLE);

    always_ff @(posedge clk_25m) begin
        if (rst)                            pkt <= '0;
        else if (state == IDLE && pkt_valid) pkt <= data_buffer;
    end

    assign hdr         = pkt[127:120];
    assign cmd         = pkt[119:112];
    assign ch          = pkt[111:104];
    assign ch_idx      = pkt[104 +: CH_W];
    assign bcast       = (ch == 8'hFF);
    assign ch_ok       = bcast || (int'(ch) < CH_NUM);
    assign mode_ok     = (ch == 8'h00) || (ch == 8'h01);
    // Bits outside the decoded fields are don't-care for this block.
    assign unused_bits = ^pkt;

`ifdef PARA_CHKSUM_EN
    logic [7:0] sum;
    always_comb begin
        sum = 8'h00;
        for (int b = 0; b < 16; b++)
            if (b != 10) sum = sum ^ pkt[b*8 +: 8];
    end
`endif

    // Priority: header, command, checksum, then channel/data.
    always_comb begin
        chk_fail = 1'b0;
        chk_code = 2'd0;
        if (hdr != 8'hA5) begin
            chk_fail = 1'b1;
            chk_code = 2'd0;
        end else if (cmd != 8'h01 && cmd != 8'h02 && cmd != 8'h03) begin
            chk_fail = 1'b1;
            chk_code = 2'd1;
        end
`ifdef PARA_CHKSUM_EN
        else if (sum != pkt[87:80]) begin
            chk_fail = 1'b1;
            chk_code = 2'd3;
        end
`endif
        else if ((cmd == 8'h02) ? !mode_ok : !ch_ok) begin
            chk_fail = 1'b1;
            chk_code = 2'd2;
        end
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            pass_q <= 1'b0;
            code_q <= 2'd0;
        end else if (state == CHECK) begin
            pass_q <= !chk_fail;
            code_q <= chk_code;
        end
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            para_cofi_flag   <= 1'b0;
            pkt_err          <= 1'b0;
            para_ch          <= 8'h00;
            channel_en       <= '0;
            contin_mode_open <= 1'b0;
            err_code         <= 2'd0;
            err_cnt          <= 8'h00;
            for (int i = 0; i < CH_NUM; i++) begin
                thr_r[i] <= '0;
                cyc_r[i] <= '0;
            end
        end else begin
            para_cofi_flag <= 1'b0;
            pkt_err        <= 1'b0;
            if (state == APPLY) begin
                if (pass_q) begin
                    unique case (1'b1)
                        cmd == 8'h01: begin
                            para_cofi_flag <= 1'b1;
                            para_ch        <= ch;
                            for (int i = 0; i < CH_NUM; i++) begin
                                if (bcast || ch_idx == CH_W'(i)) begin
                                    thr_r[i]      <= pkt[64 +: THR_W];
                                    cyc_r[i]      <= pkt[0 +: CYC_W];
                                    channel_en[i] <= 1'b1;
                                end
                            end
                        end
                        cmd == 8'h02: contin_mode_open <= ch[0];
                        cmd == 8'h03: begin
                            for (int i = 0; i < CH_NUM; i++)
                                if (bcast || ch_idx == CH_W'(i))
                                    channel_en[i] <= 1'b0;
                        end
                        default: ;
                    endcase
                end else begin
                    pkt_err  <= 1'b1;
                    err_code <= code_q;
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_pack
        assign noise_threshold[g*THR_W +: THR_W] = thr_r[g];
        assign cycle_value[g*CYC_W +: CYC_W]     = cyc_r[g];
    end

endmodule

// File: tb/tb_para_analysis_mc.sv
// Directed self-checking bench for para_analysis_mc (4 channels, 16-bit fields).
module tb_para_analysis_mc;

    logic         clk;
    logic         rst;
    logic         pkt_valid;
    logic [127:0] data_buffer;
    logic         pkt_ready;
    logic         para_cofi_flag;
    logic [7:0]   para_ch;
    logic [63:0]  noise_threshold;
    logic [63:0]  cycle_value;
    logic [3:0]   channel_en;
    logic         contin_mode_open;
    logic         pkt_err;
    logic [1:0]   err_code;
    logic [7:0]   err_cnt;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    para_analysis_mc #(.CH_NUM(4), .CH_W(2), .THR_W(16), .CYC_W(16)) dut (
        .clk_25m(clk), .rst(rst), .pkt_valid(pkt_valid),
        .data_buffer(data_buffer), .pkt_ready(pkt_ready),
        .para_cofi_flag(para_cofi_flag), .para_ch(para_ch),
        .noise_threshold(noise_threshold), .cycle_value(cycle_value),
        .channel_en(channel_en), .contin_mode_open(contin_mode_open),
        .pkt_err(pkt_err), .err_code(err_code), .err_cnt(err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] mk(input logic [7:0] h, input logic [7:0] c,
                                        input logic [7:0] chn, input logic [15:0] thr,
                                        input logic [15:0] cyc);
        logic [127:0] p;
        logic [7:0]   x;
        p = '0;
        p[127:120] = h;
        p[119:112] = c;
        p[111:104] = chn;
        p[95:88]   = 8'h5C;
        p[79:64]   = thr;
        p[63:56]   = 8'h3C;
        p[15:0]    = cyc;
        x = 8'h00;
        for (int b = 0; b < 16; b++)
            if (b != 10) x = x ^ p[b*8 +: 8];
        p[87:80] = x;
        return p;
    endfunction

    task automatic send(input logic [127:0] p, output logic cofi, output logic err);
        int n;
        n = 0;
        while (!pkt_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (pkt_ready !== 1'b1) begin
            fails++;
            $display("FAIL send_ready: pkt_ready=%b required 1", pkt_ready);
        end
        pkt_valid = 1'b1;
        data_buffer = p;
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cofi = para_cofi_flag;
        err = pkt_err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pkt_valid = 1'b0;
        data_buffer = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tests++;
        if ({pkt_ready, para_cofi_flag, pkt_err, para_ch, channel_en, contin_mode_open,
             err_code, err_cnt} !== {1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0, 8'h00}) begin
            fails++;
            $display("FAIL reset_ctrl: ready=%b cofi=%b err=%b ch=%h en=%h mode=%b code=%0d cnt=%0d",
                     pkt_ready, para_cofi_flag, pkt_err, para_ch, channel_en,
                     contin_mode_open, err_code, err_cnt);
        end
        tests++;
        if ({noise_threshold, cycle_value} !== 128'h0) begin
            fails++;
            $display("FAIL reset_regs: thr=%h cyc=%h required 0", noise_threshold, cycle_value);
        end
    endtask

    task automatic test_config();
        logic c, e;
        send(mk(8'hA5, 8'h01, 8'h02, 16'h0123, 16'h0400), c, e);
        tests++;
        if ({c, e} !== 2'b10) begin
            fails++;
            $display("FAIL cfg_pulse: cofi=%b err=%b required 1 0", c, e);
        end
        tests++;
        if (noise_threshold !== 64'h0000_0123_0000_0000) begin
            fails++;
            $display("FAIL cfg_thr: %h required 0000012300000000", noise_threshold);
        end
        tests++;
        if (cycle_value !== 64'h0000_0400_0000_0000) begin
            fails++;
            $display("FAIL cfg_cyc: %h required 0000040000000000", cycle_value);
        end
        tests++;
        if ({channel_en, para_ch} !== {4'b0100, 8'h02}) begin
            fails++;
            $display("FAIL cfg_en_ch: en=%b ch=%h required 0100 02", channel_en, para_ch);
        end
        @(posedge clk); #1;
        tests++;
        if (para_cofi_flag !== 1'b0) begin
            fails++;
            $display("FAIL cfg_pulse_width: cofi=%b required 0", para_cofi_flag);
        end
    endtask

    task automatic test_broadcast();
        logic c, e;
        send(mk(8'hA5, 8'h01, 8'hFF, 16'h0055, 16'h0010), c, e);
        tests++;
        if ({c, e, channel_en, para_ch} !== {1'b1, 1'b0, 4'hF, 8'hFF}) begin
            fails++;
            $display("FAIL bcast_ctrl: cofi=%b err=%b en=%h ch=%h required 1 0 f ff",
                     c, e, channel_en, para_ch);
        end
        tests++;
        if ({noise_threshold, cycle_value} !== {{4{16'h0055}}, {4{16'h0010}}}) begin
            fails++;
            $display("FAIL bcast_vals: thr=%h cyc=%h", noise_threshold, cycle_value);
        end
        send(mk(8'hA5, 8'h03, 8'h01, 16'hFFFF, 16'hFFFF), c, e);
        tests++;
        if ({e, channel_en} !== {1'b0, 4'b1101}) begin
            fails++;
            $display("FAIL disable_en: err=%b en=%b required 0 1101", e, channel_en);
        end
        tests++;
        if ({noise_threshold, cycle_value} !== {{4{16'h0055}}, {4{16'h0010}}}) begin
            fails++;
            $display("FAIL disable_keep: thr=%h cyc=%h", noise_threshold, cycle_value);
        end
    endtask

    task automatic test_mode();
        logic c, e;
        send(mk(8'hA5, 8'h02, 8'h01, 16'h0, 16'h0), c, e);
        tests++;
        if ({c, e, contin_mode_open} !== 3'b001) begin
            fails++;
            $display("FAIL mode_on: cofi=%b err=%b mode=%b required 0 0 1", c, e, contin_mode_open);
        end
        send(mk(8'hA5, 8'h02, 8'h07, 16'h0, 16'h0), c, e);
        exp_cnt++;
        tests++;
        if ({c, e, contin_mode_open, err_code, err_cnt} !== {3'b011, 2'd2, 8'(exp_cnt)}) begin
            fails++;
            $display("FAIL mode_bad: cofi=%b err=%b mode=%b code=%0d cnt=%0d required 0 1 1 2 %0d",
                     c, e, contin_mode_open, err_code, err_cnt, exp_cnt);
        end
    endtask

    task automatic test_errors();
        logic c, e;
        logic [127:0] p;
        logic [1:0]   exp_code [5];
        logic [127:0] vec [5];
        vec[0] = mk(8'h5A, 8'h01, 8'h00, 16'h1234, 16'h1);
        vec[1] = mk(8'hA5, 8'h09, 8'h00, 16'h1234, 16'h1);
        vec[2] = mk(8'hA5, 8'h01, 8'h04, 16'h1234, 16'h1);
        vec[3] = mk(8'h00, 8'h09, 8'h04, 16'h1234, 16'h1);
        vec[4] = mk(8'hA5, 8'h07, 8'h09, 16'h1234, 16'h1);
        exp_code[0] = 2'd0;
        exp_code[1] = 2'd1;
        exp_code[2] = 2'd2;
        exp_code[3] = 2'd0;
        exp_code[4] = 2'd1;
        for (int i = 0; i < 5; i++) begin
            send(vec[i], c, e);
            exp_cnt++;
            tests++;
            if ({c, e, err_code, err_cnt} !== {2'b01, exp_code[i], 8'(exp_cnt)}) begin
                fails++;
                $display("FAIL err_vec%0d: cofi=%b err=%b code=%0d cnt=%0d required 0 1 %0d %0d",
                         i, c, e, err_code, err_cnt, exp_code[i], exp_cnt);
            end
        end
        tests++;
        if ({channel_en, noise_threshold} !== {4'b1101, {4{16'h0055}}}) begin
            fails++;
            $display("FAIL err_nochange: en=%b thr=%h", channel_en, noise_threshold);
        end
        p = mk(8'hA5, 8'h01, 8'h00, 16'hBEEF, 16'h0022);
        p[87:80] = p[87:80] ^ 8'h01;
        send(p, c, e);
`ifdef PARA_CHKSUM_EN
        exp_cnt++;
        tests++;
        if ({c, e, err_code, err_cnt, noise_threshold[15:0]} !==
            {2'b01, 2'd3, 8'(exp_cnt), 16'h0055}) begin
            fails++;
            $display("FAIL chksum_bad: cofi=%b err=%b code=%0d cnt=%0d thr0=%h",
                     c, e, err_code, err_cnt, noise_threshold[15:0]);
        end
`else
        tests++;
        if ({c, e, err_cnt, noise_threshold[15:0], cycle_value[15:0]} !==
            {2'b10, 8'(exp_cnt), 16'hBEEF, 16'h0022}) begin
            fails++;
            $display("FAIL chksum_ignored: cofi=%b err=%b cnt=%0d thr0=%h cyc0=%h",
                     c, e, err_cnt, noise_threshold[15:0], cycle_value[15:0]);
        end
`endif
    endtask

    task automatic test_saturate();
        logic c, e;
        for (int i = 0; i < 300; i++)
            send(mk(8'h5A, 8'h01, 8'h00, 16'h0, 16'h0), c, e);
        tests++;
        if ({err_cnt, err_code} !== {8'hFF, 2'd0}) begin
            fails++;
            $display("FAIL err_sat: cnt=%h code=%0d required ff 0", err_cnt, err_code);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] rdy;
        logic [5:0] cofi;
        logic [7:0] ch_a, ch_b;
        pkt_valid = 1'b1;
        data_buffer = mk(8'hA5, 8'h01, 8'h00, 16'h1111, 16'h0001);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 0) data_buffer = mk(8'hA5, 8'h01, 8'h03, 16'h3333, 16'h0003);
            rdy[i] = pkt_ready;
            cofi[i] = para_cofi_flag;
            if (i == 2) ch_a = para_ch;
            if (i == 5) ch_b = para_ch;
        end
        pkt_valid = 1'b0;
        tests++;
        if (rdy !== 6'b100100) begin
            fails++;
            $display("FAIL b2b_ready: E0..E5 ready=%b required 100100 (msb=E5)", rdy);
        end
        tests++;
        if (cofi !== 6'b100100) begin
            fails++;
            $display("FAIL b2b_cofi: E0..E5 cofi=%b required 100100 (msb=E5)", cofi);
        end
        tests++;
        if ({ch_a, ch_b, noise_threshold[15:0], noise_threshold[63:48]} !==
            {8'h00, 8'h03, 16'h1111, 16'h3333}) begin
            fails++;
            $display("FAIL b2b_data: ch=%h,%h thr0=%h thr3=%h required 00,03 1111 3333",
                     ch_a, ch_b, noise_threshold[15:0], noise_threshold[63:48]);
        end
    endtask

    task automatic test_reset_mid();
        pkt_valid = 1'b1;
        data_buffer = mk(8'hA5, 8'h01, 8'h01, 16'hAAAA, 16'h0BBB);
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if ({pkt_ready, para_cofi_flag, pkt_err, para_ch, channel_en, contin_mode_open,
             err_code, err_cnt} !== {1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0, 8'h00}) begin
            fails++;
            $display("FAIL rst_mid_ctrl: ready=%b cofi=%b err=%b ch=%h en=%h mode=%b code=%0d cnt=%0d",
                     pkt_ready, para_cofi_flag, pkt_err, para_ch, channel_en,
                     contin_mode_open, err_code, err_cnt);
        end
        @(posedge clk); #1;
        tests++;
        if ({para_cofi_flag, noise_threshold, cycle_value} !== 129'h0) begin
            fails++;
            $display("FAIL rst_mid_regs: cofi=%b thr=%h cyc=%h required 0",
                     para_cofi_flag, noise_threshold, cycle_value);
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_broadcast();
        test_mode();
        test_errors();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/para_analysis_mc.md
Name: para_analysis_mc

Overview:
Multi-channel, parametrised successor to the single-channel parameter-packet analyser. Accepts one 128-bit command packet per handshake from the UART/packet receiver, validates header, command, channel index and (optionally) checksum, then updates a per-channel register bank (noise threshold, cycle value, enable) or the global continuous-upload mode. Sits between the packet receiver and the correlation/acquisition channels; emits a one-cycle commit pulse tagged with the channel index.

Parameters:
CH_NUM, 4, number of acquisition channels (1..255)
CH_W, 2, index width; must equal clog2(CH_NUM), minimum 1
THR_W, 16, noise-threshold width per channel (<=16; taken from LSBs of field)
CYC_W, 16, cycle-value width per channel (<=16; taken from LSBs of field)

Ports:
clk_25m  in  1  system clock
rst  in  1  synchronous, active-high reset
pkt_valid  in  1  packet present on data_buffer; sampled only when pkt_ready=1
data_buffer  in  128  packet
pkt_ready  out  1  high only in IDLE
para_cofi_flag  out  1  one-cycle commit pulse after a successful config write
para_ch  out  8  channel field of last committed config (0xFF = broadcast)
noise_threshold  out  CH_NUM*THR_W  per-channel thresholds, channel i at [i*THR_W +: THR_W]
cycle_value  out  CH_NUM*CYC_W  per-channel cycle values, same packing
channel_en  out  CH_NUM  per-channel enable mask
contin_mode_open  out  1  level: 1 continuous upload on, 0 off
pkt_err  out  1  one-cycle pulse on rejected packet
err_code  out  2  cause of last rejection: 0 header, 1 command, 2 channel/data, 3 checksum
err_cnt  out  8  saturating count of rejected packets

Behaviour:
- Packet fields: [127:120] header, must be 8'hA5; [119:112] cmd; [111:104] channel/mode byte; [87:80] checksum = XOR of the other 15 bytes; [79:64] threshold; [15:0] cycle. All other bits ignored.
- cmd 8'h01 config: channel < CH_NUM writes that channel's threshold, cycle and sets channel_en[ch]=1; 8'hFF broadcasts to all channels; any other value -> error code 2.
- cmd 8'h02 mode: byte 8'h01 -> contin_mode_open=1; 8'h00 -> 0; other -> error code 2.
- cmd 8'h03 disable: valid channel clears channel_en[ch]; 8'hFF clears all; thresholds/cycles unchanged.
- Other cmd -> error code 1. Error priority: header > cmd > checksum > channel/data.
- FSM: IDLE -> CHECK on pkt_valid (packet latched, edge E0). CHECK -> APPLY at E1 (pass/fail and error code registered). APPLY -> IDLE at E2; register writes, para_ch, err_code and err_cnt update at E2; para_cofi_flag (config commands only) or pkt_err high for exactly the cycle after E2.
- pkt_ready low in CHECK/APPLY; pkt_valid during those states is ignored (upstream holds). Next packet may be sampled at E3; max rate one packet per 3 cycles.
- Rejected packet changes no register except err_code/err_cnt. err_cnt saturates at 8'hFF.
- Reset (any cycle, including mid-FSM): state IDLE, pkt_ready=1 from the cycle after reset; all thresholds, cycle values, channel_en, contin_mode_open, para_ch, err_code, err_cnt, pulses = 0. In-flight packet discarded, no pulse.

Optional Feature:
PARA_CHKSUM_EN: defined -> checksum verified in CHECK, mismatch rejected with err_code 3. Undefined -> checksum byte ignored, code 3 never produced; latency unchanged.

Test Plan:
- Reset, then config A5/01/ch2/thr 0x0123/cyc 0x0400, good checksum -> ch2 thr=0x0123, cyc=0x0400, channel_en=4'b0100, para_cofi_flag single pulse 3 cycles after pkt_valid, para_ch=2.
- Broadcast ch 0xFF thr 0x0055 cyc 0x0010 -> all 4 channels updated, channel_en=4'hF; then cmd 03 ch1 -> channel_en=4'b1101, values retained.
- Mode cmd byte 01 -> contin_mode_open=1, no para_cofi_flag; byte 07 -> pkt_err, err_code=2, mode stays 1.
- Errors: header 0x5A -> code 0; cmd 0x09 -> code 1; ch 4 with CH_NUM=4 -> code 2; bad checksum with PARA_CHKSUM_EN -> code 3 (accepted without it); 300 bad packets -> err_cnt=8'hFF.
- Back-to-back pkt_valid held high with two packets -> second sampled only at E3; pkt_ready low 2 cycles per packet.
- Assert rst while FSM in APPLY for a valid config -> no commit pulse, all registers 0, pkt_ready=1 next cycle.
